// File: rtl/seq_mult_hs.sv
// seq_mult_hs: iterative radix-2^DIGIT signed/unsigned multiplier with valid/ready handshakes
module seq_mult_hs #(
  parameter int BITS  = 64,
  parameter int DIGIT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BITS-1:0]   a_in,
  input  logic [BITS-1:0]   b_in,
  input  logic              signed_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*BITS-1:0] product_out,
  output logic              busy
);
  localparam int STEPS = BITS / DIGIT;
  localparam int CW = STEPS > 1 ? $clog2(STEPS) : 1;
  localparam int AW = 2 * BITS + DIGIT;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state;
  logic [AW-1:0] acc, a_sh, term, sum;
  logic [BITS-1:0] b_sh, a_mag, b_mag;
  logic [CW-1:0] cnt;
  logic neg;
  always_comb begin
    a_mag = signed_en && a_in[BITS-1] ? -a_in : a_in;
    b_mag = signed_en && b_in[BITS-1] ? -b_in : b_in;
    term = '0;
    for (int j = 0; j < DIGIT; j++) term = b_sh[j] ? term + (a_sh << j) : term;
    sum = acc + term;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      in_ready <= 1'b1;
      out_valid <= 1'b0;
      busy <= 1'b0;
      product_out <= '0;
      acc <= '0;
      cnt <= '0;
      a_sh <= '0;
      b_sh <= '0;
      neg <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_sh <= {{(BITS + DIGIT){1'b0}}, a_mag};
          b_sh <= b_mag;
          neg <= signed_en & (a_in[BITS-1] ^ b_in[BITS-1]);
          acc <= '0;
          cnt <= '0;
          state <= CALC;
          in_ready <= 1'b0;
          busy <= 1'b1;
        end
        CALC: begin
          acc <= sum;
          cnt <= cnt + 1'b1;
          a_sh <= a_sh << DIGIT;
          b_sh <= b_sh >> DIGIT;
          if (cnt == CW'(STEPS - 1)) begin
            product_out <= neg ? -sum[2*BITS-1:0] : sum[2*BITS-1:0];
            state <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: if (out_ready) begin
          state <= IDLE;
          out_valid <= 1'b0;
          in_ready <= 1'b1;
          busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_mult_hs.sv
// tb_seq_mult_hs: scoreboard bench for seq_mult_hs across three width/digit configurations
module tb_seq_mult_hs;
  logic clk = 1'b0;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end
  task automatic chk(int l, string n, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL lane%0d %s: got %h expected %h", l, n, act, exp);
    end
  endtask
  task automatic fail(int l, string n);
    checks++;
    errors++;
    $display("FAIL lane%0d %s", l, n);
  endtask
  function automatic logic [127:0] model(logic [63:0] a, logic [63:0] b, bit s, int bw);
    logic signed [127:0] x, y, p;
    x = a;
    y = b;
    if (s && a[bw-1]) x = x - (128'sd1 <<< bw);
    if (s && b[bw-1]) y = y - (128'sd1 <<< bw);
    p = x * y;
    return p & ((128'd1 << (2 * bw)) - 128'd1);
  endfunction
  for (genvar g = 0; g < 3; g++) begin : lane
    localparam int B = g == 0 ? 64 : g == 1 ? 16 : 8;
    localparam int D = g == 0 ? 1 : g == 1 ? 2 : 4;
    localparam int S = B / D;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic signed_en = 1'b0;
    logic out_ready = 1'b0;
    logic in_ready, out_valid, busy;
    logic [B-1:0] a = '0;
    logic [B-1:0] b = '0;
    logic [2*B-1:0] product;
    logic [127:0] exp_q[$];
    int acc_q[$];
    bit hold = 1'b0;
    bit done = 1'b0;
    bit prev_ov = 1'b0;
    bit hs = 1'b0;
    seq_mult_hs #(.BITS(B), .DIGIT(D)) dut (
      .clk(clk), .reset(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a_in(a), .b_in(b), .signed_en(signed_en), .out_valid(out_valid),
      .out_ready(out_ready), .product_out(product), .busy(busy)
    );
    task automatic send(logic [B-1:0] av, logic [B-1:0] bv, bit s);
      int t;
      a = av;
      b = bv;
      signed_en = s;
      in_valid = 1'b1;
      for (t = 0; t < 2000 && !in_ready; t++) begin
        @(posedge clk);
        #1;
      end
      if (!in_ready) begin
        fail(g, "accept_timeout");
        in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
      exp_q.push_back(model(64'(av), 64'(bv), s, B));
      acc_q.push_back(cyc);
      in_valid = 1'b0;
      a = '1;
      b = '1;
      signed_en = ~s;
    endtask
    task automatic drain();
      int t;
      for (t = 0; t < 5000 && exp_q.size() != 0; t++) @(posedge clk);
      #1;
      if (exp_q.size() != 0) fail(g, "drain_timeout");
    endtask
    function automatic logic [B-1:0] rnd();
      logic [63:0] r;
      logic [B-1:0] v;
      int k;
      r = {$urandom, $urandom};
      k = $urandom_range(0, 7);
      v = B'(r);
      if (k == 0) begin
        v = '0;
        v[B-1] = 1'b1;
      end
      return k == 1 ? '1 : k == 2 ? '0 : v;
    endfunction
    initial forever begin
      @(posedge clk);
      #1;
      out_ready = !hold && ($urandom_range(0, 3) != 0);
    end
    always @(negedge clk) begin
      if (rst) begin
        prev_ov = 1'b0;
        hs = 1'b0;
      end else begin
        if (hs) begin
          chk(g, "ready_after_hs", 128'(in_ready), 128'd1);
          chk(g, "valid_drop_after_hs", 128'(out_valid), 128'd0);
        end
        hs = 1'b0;
        if (out_valid && !prev_ov) begin
          if (acc_q.size() == 0) fail(g, "spurious_out_valid");
          else chk(g, "latency", 128'(cyc - acc_q.pop_front()), 128'(S));
          chk(g, "busy_in_done", 128'(busy), 128'd1);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) fail(g, "extra_result");
          else chk(g, "product", 128'(product), exp_q.pop_front());
          hs = 1'b1;
        end
        prev_ov = out_valid;
      end
    end
    initial begin
      logic [B-1:0] mn, mx;
      logic [127:0] e;
      mn = '0;
      mn[B-1] = 1'b1;
      mx = '1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk(g, "reset_in_ready", 128'(in_ready), 128'd1);
      chk(g, "reset_out_valid", 128'(out_valid), 128'd0);
      chk(g, "reset_busy", 128'(busy), 128'd0);
      chk(g, "reset_product", 128'(product), 128'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      send(mx, mx, 1'b0);
      send(B'(-3), B'(7), 1'b1);
      send(mn, mn, 1'b1);
      send(mn, mn, 1'b0);
      send(mx, mx, 1'b1);
      send(mx, '0, 1'b0);
      send('0, mn, 1'b1);
      send(mn, mx >> 1, 1'b1);
      drain();
      send(B'(12345), B'(678), 1'b0);
      repeat (S / 2 - 2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk(g, "abort_in_ready", 128'(in_ready), 128'd1);
      chk(g, "abort_out_valid", 128'(out_valid), 128'd0);
      chk(g, "abort_busy", 128'(busy), 128'd0);
      chk(g, "abort_product", 128'(product), 128'd0);
      rst = 1'b0;
      void'(exp_q.pop_back());
      void'(acc_q.pop_back());
      @(posedge clk);
      #1;
      send(B'(5), B'(6), 1'b0);
      drain();
      hold = 1'b1;
      send(mn, B'(3), 1'b1);
      e = exp_q[0];
      for (int t = 0; t < 2000 && !out_valid; t++) @(negedge clk);
      for (int i = 0; i < 10; i++) begin
        chk(g, "hold_out_valid", 128'(out_valid), 128'd1);
        chk(g, "hold_in_ready", 128'(in_ready), 128'd0);
        chk(g, "hold_product", 128'(product), e);
        @(posedge clk);
        #1;
        in_valid = 1'($urandom);
        a = rnd();
        b = rnd();
        signed_en = 1'($urandom);
        @(negedge clk);
      end
      in_valid = 1'b0;
      hold = 1'b0;
      @(posedge clk);
      #1;
      for (int i = 0; i < 100; i++) begin
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
        send(rnd(), rnd(), 1'($urandom));
      end
      drain();
      if (acc_q.size() != 0) fail(g, "latency_queue_left");
      done = 1'b1;
    end
  end
  initial begin
    for (int t = 0; t < 90000 && !(lane[0].done && lane[1].done && lane[2].done); t++) @(posedge clk);
    if (!(lane[0].done && lane[1].done && lane[2].done)) fail(-1, "global_timeout");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
